sh7604_pdc: RTL and testbench
=============================

SH7604_PDC -- requirements
Module: sh7604_pdc

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 256, meaning oscillator-settling wait after standby exit, in CE_R ticks (range 1..65535).
REQ-002 SHALL have port CLK, input, 1, system clock.
REQ-003 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port CE_R, input, 1, rising-phase clock enable; all state advances only when EN && CE_R.
REQ-005 SHALL have port EN, input, 1, block enable; EN=0 freezes all state.
REQ-006 SHALL have port RES_N, input, 1, synchronous active-low soft reset, sampled on EN && CE_R.
REQ-007 SHALL have port SBY, input, 1, standby-select bit from SBYCR.
REQ-008 SHALL have port SLEEP_REQ, input, 1, CPU executing SLEEP instruction.
REQ-009 SHALL have port BUS_IDLE, input, 1, no internal/external bus cycle outstanding.
REQ-010 SHALL have port IRQ_PEND, input, 1, unmasked maskable interrupt pending.
REQ-011 SHALL have port NMI, input, 1, NMI request level.
REQ-012 SHALL have port CPU_HOLD, output, 1, stall CPU instruction issue.
REQ-013 SHALL have port CPU_STOP, output, 1, gate CPU core clock enable.
REQ-014 SHALL have port PER_STOP, output, 1, gate on-chip peripheral clock enables.
REQ-015 SHALL have port MOD_RST, output, 1, hold peripherals (FRT, SCI, DMAC, WDT) in module reset.
REQ-016 SHALL have port WAKE_ACK, output, 1, one-tick pulse on return to run.
REQ-017 SHALL have port STATE, output, 3, current state encoding for debug.

Function
REQ-018 SHALL implement states RUN=0, DRAIN=1, SLEEP=2, STBY=3, SETTLE=4, WAKE=5; codes 6,7 SHALL return to RUN next tick.
REQ-019 RUN: SLEEP_REQ=1 SHALL latch SBY into internal MODE and go to DRAIN; SLEEP_REQ in any other state SHALL be ignored.
REQ-020 DRAIN: CPU_HOLD=1; when BUS_IDLE=1 SHALL go to SLEEP if MODE=0, else STBY; no timeout.
REQ-021 SLEEP: CPU_HOLD=CPU_STOP=1, PER_STOP=0; IRQ_PEND=1 or NMI=1 SHALL go to WAKE.
REQ-022 STBY: CPU_HOLD=CPU_STOP=PER_STOP=MOD_RST=1; only NMI=1 SHALL exit, to SETTLE; IRQ_PEND SHALL be ignored.
REQ-023 SETTLE: CPU_HOLD=CPU_STOP=PER_STOP=1, MOD_RST=0; 16-bit counter loaded with SETTLE_CYC-1 on entry, decremented per tick; at 0 SHALL go to WAKE, so SETTLE lasts exactly SETTLE_CYC ticks.
REQ-024 WAKE: CPU_HOLD=1, CPU_STOP=PER_STOP=0, WAKE_ACK=1 for exactly one tick, then RUN.
REQ-025 Outputs SHALL be registered from state (Moore); output change SHALL appear the tick the state is entered.
REQ-026 SBY changes after the SLEEP_REQ latch SHALL not affect the current power-down episode.
REQ-027 IRQ_PEND and NMI both asserted in SLEEP SHALL give a single WAKE; NMI deasserting during SETTLE SHALL not abort SETTLE.
REQ-028 SLEEP_REQ and BUS_IDLE both high in RUN SHALL still pass through DRAIN (minimum 1 tick).
REQ-029 RES_N=0 in any state SHALL force RUN, clear MODE and counter, deassert all outputs; RES_N takes priority over every other input.

Reset
REQ-030 RST_N=0 SHALL asynchronously force STATE=RUN, MODE=0, counter=0, CPU_HOLD=CPU_STOP=PER_STOP=MOD_RST=WAKE_ACK=0.
REQ-031 After RST_N release, first transition SHALL occur on the first tick with EN && CE_R.

Verification
REQ-032 SBY=0, SLEEP_REQ pulse, BUS_IDLE=1 -> DRAIN 1 tick, SLEEP (CPU_STOP=1, PER_STOP=0); IRQ_PEND=1 -> WAKE, WAKE_ACK 1 tick, RUN.
REQ-033 SBY=1, SLEEP_REQ, BUS_IDLE low 5 ticks -> DRAIN held 6 ticks, then STBY with MOD_RST=1; IRQ_PEND=1 -> remains STBY.
REQ-034 SETTLE_CYC=4, in STBY assert NMI -> SETTLE exactly 4 ticks, WAKE, RUN; toggling NMI during SETTLE has no effect.
REQ-035 In SETTLE assert RES_N=0 -> next tick RUN, all outputs 0; CE_R held low 10 ticks in SLEEP with IRQ_PEND -> no transition until CE_R=1.
REQ-036 Assert RST_N=0 mid-STBY between clock edges -> outputs 0 immediately without a CLK edge.

Source files
------------

// File: rtl/sh7604_pdc.sv
// ---------------------------------------------------------------------------
// sh7604_pdc -- power-down controller for the SH7604 core.
//
// This block sequences the CPU through sleep and software standby.
// - SLEEP mode stops only the CPU clock.
// - Standby mode also stops the peripheral clocks and holds the peripherals
//   in module reset.
// - Leaving standby passes through an oscillator-settling wait of SETTLE_CYC
//   ticks.
// A "tick" is any CLK edge that has EN && CE_R high. All outputs are Moore
// outputs, registered from the state being entered.
//
// Parameters
//   SETTLE_CYC : oscillator settling wait after standby exit, in ticks (1..65535)
//
// Ports
//   CLK        : system clock
//   RST_N      : asynchronous active-low reset
//   CE_R       : rising-phase clock enable
//   EN         : block enable, 0 freezes all state
//   RES_N      : synchronous active-low soft reset (sampled on a tick)
//   SBY        : standby-select bit from SBYCR
//   SLEEP_REQ  : CPU is executing SLEEP
//   BUS_IDLE   : no bus cycle outstanding
//   IRQ_PEND   : unmasked maskable interrupt pending
//   NMI        : NMI request level
//   CPU_HOLD   : stall CPU instruction issue
//   CPU_STOP   : gate CPU core clock enable
//   PER_STOP   : gate peripheral clock enables
//   MOD_RST    : hold FRT/SCI/DMAC/WDT in module reset
//   WAKE_ACK   : one-tick pulse on return to run
//   STATE      : current state encoding (debug)
// ---------------------------------------------------------------------------
module sh7604_pdc #(
  parameter int unsigned SETTLE_CYC = 256
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       EN,
  input  logic       RES_N,
  input  logic       SBY,
  input  logic       SLEEP_REQ,
  input  logic       BUS_IDLE,
  input  logic       IRQ_PEND,
  input  logic       NMI,
  output logic       CPU_HOLD,
  output logic       CPU_STOP,
  output logic       PER_STOP,
  output logic       MOD_RST,
  output logic       WAKE_ACK,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_DRAIN  = 3'd1,
    S_SLEEP  = 3'd2,
    S_STBY   = 3'd3,
    S_SETTLE = 3'd4,
    S_WAKE   = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

  state_t      state_q;
  state_t      state_d;
  logic        mode_q;
  logic [15:0] cnt_q;
  logic [4:0]  out_d;

  // Next-state decode.
  // MODE holds the SBY value captured at the SLEEP instruction. This means a
  // later SBY write cannot redirect an episode that has already started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (SLEEP_REQ)          state_d = S_DRAIN;
      S_DRAIN:  if (BUS_IDLE)           state_d = mode_q ? S_STBY : S_SLEEP;
      S_SLEEP:  if (IRQ_PEND || NMI)    state_d = S_WAKE;
      S_STBY:   if (NMI)                state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == 16'd0)     state_d = S_WAKE;
      S_WAKE:                           state_d = S_RUN;
      default:                          state_d = S_RUN;
    endcase
  end

  // Output decode for the state being entered.
  // The decode is registered below, so each output changes on the same tick
  // as the state it belongs to.
  // Bit order: {CPU_HOLD, CPU_STOP, PER_STOP, MOD_RST, WAKE_ACK}.
  always_comb begin
    out_d = 5'b00000;
    case (state_d)
      S_DRAIN:  out_d = 5'b10000;
      S_SLEEP:  out_d = 5'b11000;
      S_STBY:   out_d = 5'b11110;
      S_SETTLE: out_d = 5'b11100;
      S_WAKE:   out_d = 5'b10001;
      default:  out_d = 5'b00000;
    endcase
  end

  // State, episode mode, settle counter and registered outputs.
  // The soft reset overrides everything else on a tick.
  // The settle counter is loaded on entry to SETTLE and counts down to zero.
  // This keeps SETTLE active for exactly SETTLE_CYC ticks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_RUN;
      mode_q   <= 1'b0;
      cnt_q    <= 16'd0;
      CPU_HOLD <= 1'b0;
      CPU_STOP <= 1'b0;
      PER_STOP <= 1'b0;
      MOD_RST  <= 1'b0;
      WAKE_ACK <= 1'b0;
    end else if (EN && CE_R) begin
      if (!RES_N) begin
        state_q  <= S_RUN;
        mode_q   <= 1'b0;
        cnt_q    <= 16'd0;
        CPU_HOLD <= 1'b0;
        CPU_STOP <= 1'b0;
        PER_STOP <= 1'b0;
        MOD_RST  <= 1'b0;
        WAKE_ACK <= 1'b0;
      end else begin
        state_q <= state_d;
        if (state_q == S_RUN && SLEEP_REQ)
          mode_q <= SBY;
        if (state_d == S_SETTLE && state_q != S_SETTLE)
          cnt_q <= SETTLE_LOAD;
        else if (state_q == S_SETTLE && cnt_q != 16'd0)
          cnt_q <= cnt_q - 16'd1;
        {CPU_HOLD, CPU_STOP, PER_STOP, MOD_RST, WAKE_ACK} <= out_d;
      end
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_sh7604_pdc.sv
// ---------------------------------------------------------------------------
// tb_sh7604_pdc -- self-checking bench for sh7604_pdc (SETTLE_CYC = 4).
//
// The bench first applies a directed sequence through sleep, standby, settle,
// soft reset, clock-enable gating and asynchronous reset. It then runs a
// randomized phase.
//
// On every tick the DUT is compared with a behavioural model of the power
// modes. The model tracks:
// - the current mode,
// - the episode mode captured at SLEEP,
// - the number of settle ticks remaining.
// ---------------------------------------------------------------------------
module tb_sh7604_pdc;

  localparam int SETTLE = 4;

  localparam int RUN = 0, DRAIN = 1, SLEEPS = 2, STBY = 3, SETL = 4, WAKE = 5;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CE_R, EN, RES_N, SBY, SLEEP_REQ, BUS_IDLE, IRQ_PEND, NMI;
  logic       CPU_HOLD, CPU_STOP, PER_STOP, MOD_RST, WAKE_ACK;
  logic [2:0] STATE;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int m_st = RUN;
  bit m_standby = 1'b0;
  int m_left = 0;

  sh7604_pdc #(.SETTLE_CYC(SETTLE)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .EN(EN), .RES_N(RES_N),
    .SBY(SBY), .SLEEP_REQ(SLEEP_REQ), .BUS_IDLE(BUS_IDLE),
    .IRQ_PEND(IRQ_PEND), .NMI(NMI),
    .CPU_HOLD(CPU_HOLD), .CPU_STOP(CPU_STOP), .PER_STOP(PER_STOP),
    .MOD_RST(MOD_RST), .WAKE_ACK(WAKE_ACK), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Expected {CPU_HOLD, CPU_STOP, PER_STOP, MOD_RST, WAKE_ACK} for each mode.
  function automatic logic [4:0] mode_outputs(input int st);
    case (st)
      DRAIN:   return 5'b10000;
      SLEEPS:  return 5'b11000;
      STBY:    return 5'b11110;
      SETL:    return 5'b11100;
      WAKE:    return 5'b10001;
      default: return 5'b00000;
    endcase
  endfunction

  // Return the model to its power-on condition.
  task automatic model_reset();
    m_st = RUN;
    m_standby = 1'b0;
    m_left = 0;
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_tick();
    if (!(EN && CE_R)) return;
    if (!RES_N) begin
      model_reset();
      return;
    end
    case (m_st)
      RUN:
        if (SLEEP_REQ) begin
          m_standby = SBY;
          m_st = DRAIN;
        end
      DRAIN:
        if (BUS_IDLE) m_st = m_standby ? STBY : SLEEPS;
      SLEEPS:
        if (IRQ_PEND || NMI) m_st = WAKE;
      STBY:
        if (NMI) begin
          m_st = SETL;
          m_left = SETTLE;
        end
      SETL: begin
        m_left = m_left - 1;
        if (m_left == 0) m_st = WAKE;
      end
      default:
        m_st = RUN;
    endcase
  endtask

  // Drive all functional inputs.
  task automatic applyStimulus(input logic sleep, input logic sby, input logic idle,
                               input logic irq, input logic nmi, input logic ce,
                               input logic en, input logic res_n);
    SLEEP_REQ = sleep;
    SBY       = sby;
    BUS_IDLE  = idle;
    IRQ_PEND  = irq;
    NMI       = nmi;
    CE_R      = ce;
    EN        = en;
    RES_N     = res_n;
  endtask

  // Compare the DUT state and outputs with the model.
  task automatic checkOutput(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {CPU_HOLD, CPU_STOP, PER_STOP, MOD_RST, WAKE_ACK};
    exp = mode_outputs(m_st);
    checks++;
    assert (STATE === 3'(m_st)) else begin
      failures++;
      $display("[TB] FAIL %s.state observed=%0d expected=%0d at %0t", tag, STATE, m_st, $time);
      $error("[TB] %s state differs", tag);
    end
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s.outs observed=%b expected=%b at %0t", tag, obs, exp, $time);
      $error("[TB] %s outputs differ", tag);
    end
  endtask

  // Compare the DUT state with a fixed, directly stated mode.
  task automatic expectState(input string tag, input int st);
    checks++;
    assert (STATE === 3'(st)) else begin
      failures++;
      $display("[TB] FAIL %s.fixed observed=%0d expected=%0d at %0t", tag, STATE, st, $time);
      $error("[TB] %s fixed state differs", tag);
    end
  endtask

  // Advance one clock edge, then check the DUT 1 ns after the edge.
  task automatic step(input string tag);
    @(posedge CLK);
    model_tick();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    RST_N = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    model_reset();

    #3;
    checkOutput("reset");
    #9 RST_N = 1'b1;
    step("idle");
    expectState("idle", RUN);

    // Sleep entry with the bus already idle; an interrupt wakes the CPU.
    applyStimulus(1, 0, 1, 0, 0, 1, 1, 1);
    step("slp_drain");
    expectState("slp_drain", DRAIN);
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 1);
    step("slp_enter");
    expectState("slp_enter", SLEEPS);
    step("slp_hold");
    applyStimulus(0, 0, 1, 1, 0, 1, 1, 1);
    step("slp_wake");
    expectState("slp_wake", WAKE);
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 1);
    step("slp_run");
    expectState("slp_run", RUN);

    // Standby entry with the bus busy; SBY is cleared after the latch.
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 1);
    step("sby_drain0");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step("sby_drainN");
    expectState("sby_drain_held", DRAIN);
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 1);
    step("sby_enter");
    expectState("sby_enter", STBY);
    applyStimulus(0, 0, 1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step("sby_irq_ignored");
    expectState("sby_irq_ignored", STBY);

    // NMI exit from standby; toggling NMI does not disturb the settle wait.
    applyStimulus(0, 0, 1, 0, 1, 1, 1, 1);
    step("settle_enter");
    expectState("settle_enter", SETL);
    for (int i = 0; i < SETTLE - 1; i++) begin
      NMI = ~NMI;
      step("settle_hold");
      expectState("settle_hold", SETL);
    end
    NMI = 1'b0;
    step("settle_wake");
    expectState("settle_wake", WAKE);
    step("settle_run");
    expectState("settle_run", RUN);

    // Soft reset during the settle wait.
    applyStimulus(1, 1, 1, 0, 0, 1, 1, 1);
    step("sr_drain");
    applyStimulus(0, 1, 1, 0, 1, 1, 1, 1);
    step("sr_stby");
    step("sr_settle");
    applyStimulus(0, 1, 1, 0, 1, 1, 1, 0);
    step("sr_reset");
    expectState("sr_reset", RUN);

    // A low CE_R blocks the wakeup until it is raised again.
    applyStimulus(1, 0, 1, 0, 0, 1, 1, 1);
    step("ce_drain");
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 1);
    step("ce_sleep");
    applyStimulus(0, 0, 1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) step("ce_gated");
    expectState("ce_gated", SLEEPS);
    CE_R = 1'b1;
    step("ce_wake");
    expectState("ce_wake", WAKE);
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 1);
    step("ce_run");

    // Asynchronous reset asserted between edges while in standby.
    applyStimulus(1, 1, 1, 0, 0, 1, 1, 1);
    step("ar_drain");
    applyStimulus(0, 1, 1, 0, 0, 1, 1, 1);
    step("ar_stby");
    expectState("ar_stby", STBY);
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    checkOutput("ar_async");
    @(negedge CLK);
    RST_N = 1'b1;

    // Randomized phase.
    for (int n = 0; n < 800; n++) begin
      applyStimulus(($urandom_range(3) == 0), 1'($urandom), 1'($urandom),
                    ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                    ($urandom_range(3) != 0), ($urandom_range(7) != 0),
                    ($urandom_range(40) != 0));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
